// File: rtl/decoder_seq.sv
// decoder_seq: registered binary-to-one-hot decoder with single-beat DECODE and NUM_OUT-beat SWEEP modes
module decoder_seq #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] y,
  output logic               err,
  output logic               busy
);
  localparam int CW = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] ONE = NUM_OUT'(1);
  typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_idx, r_beat, w_nidx;
  logic [NUM_OUT-1:0] r_y;
  logic r_err, r_valid, w_bad, w_last;
  // range check on the full-width index so out-of-range values are never aliased
  assign w_bad = 32'(sel) >= 32'(NUM_OUT);
  assign w_last = r_beat == LAST;
  assign w_nidx = (r_idx == LAST) ? '0 : r_idx + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? ((w_bad || !mode) ? HOLD : SWEEP) : IDLE;
      HOLD:    w_next = out_ready ? IDLE : HOLD;
      SWEEP:   w_next = (out_ready && w_last) ? IDLE : SWEEP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = (r_state == IDLE) && !rst;
    busy      = r_state != IDLE;
    out_valid = r_valid;
    y         = r_y;
    err       = r_err;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_beat  <= '0;
    end else if (r_state == IDLE) begin
      if (in_valid) begin
        r_valid <= 1'b1;
        r_err   <= w_bad;
        r_y     <= w_bad ? '0 : ONE << sel;
        r_idx   <= CW'(sel);
        r_beat  <= '0;
      end
    end else if (out_ready) begin
      if (r_state == HOLD || w_last) begin
        r_y     <= '0;
        r_err   <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_idx  <= w_nidx;
        r_beat <= r_beat + 1'b1;
        r_y    <= ONE << w_nidx;
      end
    end
  end
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed plus random stimulus on an 8-output and a 6-output decoder, checked against a beat-list model
module tb_decoder_seq;
  logic clk = 1'b0;
  logic rst, in_valid, mode, out_ready;
  logic [2:0] sel;
  logic ir8, ov8, err8, busy8, ir6, ov6, err6, busy6;
  logic [7:0] y8;
  logic [5:0] y6;
  int n_chk = 0;
  int n_err = 0;
  logic [8:0] mq [2][8];
  int pos [2];
  int cnt [2];
  always #5 clk = ~clk;
  decoder_seq #(.SEL_W(3), .NUM_OUT(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .sel(sel), .mode(mode),
    .out_valid(ov8), .out_ready(out_ready), .y(y8), .err(err8), .busy(busy8)
  );
  decoder_seq #(.SEL_W(3), .NUM_OUT(6)) u6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir6), .sel(sel), .mode(mode),
    .out_valid(ov6), .out_ready(out_ready), .y(y6), .err(err6), .busy(busy6)
  );
  // the model keeps each request as the full list of beats it must produce, consumed one per accept
  always @(posedge clk) begin
    int n;
    for (int d = 0; d < 2; d++) begin
      n = d ? 6 : 8;
      if (rst) begin
        pos[d] = 0;
        cnt[d] = 0;
      end else if (pos[d] == cnt[d]) begin
        if (in_valid) begin
          pos[d] = 0;
          if (int'(sel) >= n) begin
            mq[d][0] = 9'h100;
            cnt[d] = 1;
          end else if (!mode) begin
            mq[d][0] = 9'(1) << sel;
            cnt[d] = 1;
          end else begin
            for (int k = 0; k < n; k++) mq[d][k] = 9'(1) << ((int'(sel) + k) % n);
            cnt[d] = n;
          end
        end
      end else if (out_ready) pos[d]++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    logic [8:0] b;
    logic v;
    for (int d = 0; d < 2; d++) begin
      v = pos[d] < cnt[d];
      b = v ? mq[d][pos[d]] : 9'h000;
      if (d == 0) begin
        check("ov8", 32'(ov8), 32'(v));
        check("y8", 32'(y8), 32'(b[7:0]));
        check("err8", 32'(err8), 32'(b[8]));
        check("busy8", 32'(busy8), 32'(v));
        check("ir8", 32'(ir8), 32'(!v && !rst));
      end else begin
        check("ov6", 32'(ov6), 32'(v));
        check("y6", 32'(y6), 32'(b[5:0]));
        check("err6", 32'(err6), 32'(b[8]));
        check("busy6", 32'(busy6), 32'(v));
        check("ir6", 32'(ir6), 32'(!v && !rst));
      end
    end
  endtask
  task automatic step(input logic r, input logic iv, input logic [2:0] s, input logic m, input logic o);
    @(negedge clk);
    check_all();
    rst = r;
    in_valid = iv;
    sel = s;
    mode = m;
    out_ready = o;
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    sel = '0;
    mode = 1'b0;
    out_ready = 1'b0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int s = 0; s < 8; s++) begin
      step(0, 1, 3'(s), 0, 1);
      step(0, 1, 3'(s), 0, 1);
    end
    step(0, 0, 0, 0, 1);
    step(0, 1, 5, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 6, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, (i != 3 && i != 4));
    step(0, 1, 7, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 2, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(63) == 0), $urandom_range(1), 3'($urandom_range(7)),
           $urandom_range(1), ($urandom_range(9) < 7));
    step(0, 0, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
